cr_clic_int_hsk: RTL

CR_CLIC_INT_HSK -- requirements
Module: cr_clic_int_hsk

---
 rtl/cr_clic_int_hsk_if.sv | 74 +++++++
 rtl/cr_clic_int_hsk.sv | 108 ++++++++++
 2 files changed

// File: rtl/cr_clic_int_hsk_if.sv
// CLIC-to-core interrupt handshake bundle: arbiter winner, cp0 state, core request/ack, kid clear.
// CLIC_INT_THRESH_EN adds the cp0_clic_mintthresh level threshold.
interface cr_clic_int_hsk_if #(
  parameter int ID_WIDTH = 12
);
  logic [ID_WIDTH-1:0] arb_ctrl_int_id;
  logic [7:0]          arb_ctrl_int_il;
  logic                arb_ctrl_int_hv;
  logic                arb_ctrl_int_mode;
  logic                cp0_clic_int_en;
  logic [7:0]          cp0_clic_mil;
`ifdef CLIC_INT_THRESH_EN
  logic [7:0]          cp0_clic_mintthresh;
`endif
  logic                cpu_clic_int_ack;
  logic                clic_cpu_int_req;
  logic [ID_WIDTH-1:0] clic_cpu_int_id;
  logic [7:0]          clic_cpu_int_il;
  logic                clic_cpu_int_hv;
  logic                clic_cpu_int_mode;
  logic                ctrl_kid_int_clr;
  logic [ID_WIDTH-1:0] ctrl_kid_int_clr_id;
  logic                ctrl_busy;

`ifdef CLIC_INT_THRESH_EN
  modport slave (
    input  arb_ctrl_int_id, arb_ctrl_int_il,
    input  arb_ctrl_int_hv, arb_ctrl_int_mode,
    input  cp0_clic_int_en, cp0_clic_mil,
    input  cp0_clic_mintthresh,
    input  cpu_clic_int_ack,
    output clic_cpu_int_req, clic_cpu_int_id,
    output clic_cpu_int_il, clic_cpu_int_hv,
    output clic_cpu_int_mode,
    output ctrl_kid_int_clr, ctrl_kid_int_clr_id,
    output ctrl_busy
  );
  modport master (
    output arb_ctrl_int_id, arb_ctrl_int_il,
    output arb_ctrl_int_hv, arb_ctrl_int_mode,
    output cp0_clic_int_en, cp0_clic_mil,
    output cp0_clic_mintthresh,
    output cpu_clic_int_ack,
    input  clic_cpu_int_req, clic_cpu_int_id,
    input  clic_cpu_int_il, clic_cpu_int_hv,
    input  clic_cpu_int_mode,
    input  ctrl_kid_int_clr, ctrl_kid_int_clr_id,
    input  ctrl_busy
  );
`else
  modport slave (
    input  arb_ctrl_int_id, arb_ctrl_int_il,
    input  arb_ctrl_int_hv, arb_ctrl_int_mode,
    input  cp0_clic_int_en, cp0_clic_mil,
    input  cpu_clic_int_ack,
    output clic_cpu_int_req, clic_cpu_int_id,
    output clic_cpu_int_il, clic_cpu_int_hv,
    output clic_cpu_int_mode,
    output ctrl_kid_int_clr, ctrl_kid_int_clr_id,
    output ctrl_busy
  );
  modport master (
    output arb_ctrl_int_id, arb_ctrl_int_il,
    output arb_ctrl_int_hv, arb_ctrl_int_mode,
    output cp0_clic_int_en, cp0_clic_mil,
    output cpu_clic_int_ack,
    input  clic_cpu_int_req, clic_cpu_int_id,
    input  clic_cpu_int_il, clic_cpu_int_hv,
    input  clic_cpu_int_mode,
    input  ctrl_kid_int_clr, ctrl_kid_int_clr_id,
    input  ctrl_busy
  );
`endif
endinterface

// File: rtl/cr_clic_int_hsk.sv
// CLIC interrupt request/ack handshake FSM towards the core (IDLE/REQ/CLR/WAIT).
// Define CLIC_INT_THRESH_EN to also gate requests on cp0_clic_mintthresh.
module cr_clic_int_hsk #(
  parameter int ID_WIDTH = 12
) (
  input logic            out_clk,
  input logic            cpurst_b,
  cr_clic_int_hsk_if.slave hsk
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CLR,
    WAIT
  } state_t;

  state_t              state_q;
  logic                req_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [7:0]          il_q;
  logic                hv_q;
  logic                mode_q;
  logic                clr_q;
  logic [ID_WIDTH-1:0] clr_id_q;
  logic                thr_ok;
  logic                cand;
  logic                new_id;

`ifdef CLIC_INT_THRESH_EN
  assign thr_ok = hsk.arb_ctrl_int_il > hsk.cp0_clic_mintthresh;
`else
  assign thr_ok = 1'b1;
`endif

  assign cand = hsk.cp0_clic_int_en
              & (hsk.arb_ctrl_int_il != 8'd0)
              & (hsk.arb_ctrl_int_il > hsk.cp0_clic_mil)
              & thr_ok;

  assign new_id = hsk.arb_ctrl_int_id != id_q;

  always_ff @(posedge out_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      id_q     <= '0;
      il_q     <= '0;
      hv_q     <= 1'b0;
      mode_q   <= 1'b0;
      clr_q    <= 1'b0;
      clr_id_q <= '0;
    end else begin
      clr_q    <= 1'b0;
      clr_id_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (cand) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            id_q    <= hsk.arb_ctrl_int_id;
            il_q    <= hsk.arb_ctrl_int_il;
            hv_q    <= hsk.arb_ctrl_int_hv;
            mode_q  <= hsk.arb_ctrl_int_mode;
          end
        end
        REQ: begin
          // ack wins over reload/withdraw; clear the id the core saw
          if (hsk.cpu_clic_int_ack) begin
            state_q  <= CLR;
            clr_q    <= 1'b1;
            clr_id_q <= id_q;
            req_q    <= 1'b0;
            id_q     <= '0;
            il_q     <= '0;
            hv_q     <= 1'b0;
            mode_q   <= 1'b0;
          end else if (!cand) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            id_q    <= '0;
            il_q    <= '0;
            hv_q    <= 1'b0;
            mode_q  <= 1'b0;
          end else if (new_id) begin
            id_q   <= hsk.arb_ctrl_int_id;
            il_q   <= hsk.arb_ctrl_int_il;
            hv_q   <= hsk.arb_ctrl_int_hv;
            mode_q <= hsk.arb_ctrl_int_mode;
          end
        end
        CLR:     state_q <= WAIT;
        WAIT:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hsk.clic_cpu_int_req    = req_q;
  assign hsk.clic_cpu_int_id     = id_q;
  assign hsk.clic_cpu_int_il     = il_q;
  assign hsk.clic_cpu_int_hv     = hv_q;
  assign hsk.clic_cpu_int_mode   = mode_q;
  assign hsk.ctrl_kid_int_clr    = clr_q;
  assign hsk.ctrl_kid_int_clr_id = clr_id_q;
  assign hsk.ctrl_busy           = (state_q != IDLE) | req_q;

endmodule
